addr_stack: RTL and testbench

//  Parametrised program-address stack: program counter plus DEPTH-level return stack.

---
 rtl/addr_stack_pkg.sv | 25 ++
 rtl/addr_stack_return_stack.sv | 93 +++++++++
 rtl/addr_stack.sv | 125 ++++++++++++
 tb/tb_addr_stack.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/addr_stack_pkg.sv
// Shared opcode and state encodings for the program-address stack.
package addr_stack_pkg;

    typedef enum logic [2:0] {
        OpFetch = 3'd0,
        OpJump  = 3'd1,
        OpCall  = 3'd2,
        OpRet   = 3'd3,
        OpJpage = 3'd4,
        OpClrf  = 3'd5,
        OpRsv6  = 3'd6,
        OpRsv7  = 3'd7
    } op_e;

    typedef enum logic {
        StIdle = 1'b0,
        StEmit = 1'b1
    } state_e;

    // Index width that stays at least one bit for single-entry structures.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/addr_stack_return_stack.sv
// Circular return stack with saturating occupancy, wrap/trap policy and sticky flags.
module addr_stack_return_stack
    import addr_stack_pkg::*;
#(
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned OVF_MODE = 0
) (
    input  logic                         sysclk,
    input  logic                         poc,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clr_flags,
    input  logic [ADDR_W-1:0]            push_data,
    output logic [ADDR_W-1:0]            pop_data,
    output logic                         push_ok,
    output logic                         pop_ok,
    output logic [$clog2(DEPTH+1)-1:0]   depth_cnt,
    output logic                         ovf,
    output logic                         unf
);

    localparam int unsigned SP_W  = idx_w(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [SP_W-1:0]  SpMax  = SP_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [SP_W-1:0]   sp_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ovf_q;
    logic              unf_q;
    logic [SP_W-1:0]   sp_inc;
    logic [SP_W-1:0]   sp_dec;
    logic              full;
    logic              empty;

    always_comb begin
        full    = (cnt_q == CntMax);
        empty   = (cnt_q == '0);
        sp_inc  = (sp_q == SpMax) ? '0 : sp_q + SP_W'(1);
        sp_dec  = (sp_q == '0) ? SpMax : sp_q - SP_W'(1);
        // Wrap mode always moves the pointer; trap mode refuses at the limits.
        push_ok = push && ((OVF_MODE == 0) || !full);
        pop_ok  = pop && ((OVF_MODE == 0) || !empty);
    end

    assign pop_data  = mem_q[sp_dec];
    assign depth_cnt = cnt_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;

    always_ff @(posedge sysclk) begin
        if (poc) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            sp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (clr_flags) begin
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end
            if (push) begin
                if (full) begin
                    ovf_q <= 1'b1;
                end
                if (push_ok) begin
                    mem_q[sp_q] <= push_data;
                    sp_q        <= sp_inc;
                    if (!full) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            end
            if (pop) begin
                if (empty) begin
                    unf_q <= 1'b1;
                end
                if (pop_ok) begin
                    sp_q <= sp_dec;
                    if (!empty) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/addr_stack.sv
// Program counter with return stack; FETCH emits the PC nibble-serially while rippling +1.
module addr_stack
    import addr_stack_pkg::*;
#(
    parameter int unsigned NIB_W    = 4,
    parameter int unsigned N_NIB    = 3,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned OVF_MODE = 0,
    localparam int unsigned ADDR_W  = NIB_W * N_NIB
) (
    input  logic                         sysclk,
    input  logic                         poc,
    input  logic                         cmd_valid,
    input  logic [2:0]                   cmd_op,
    input  logic [ADDR_W-1:0]            cmd_addr,
    output logic                         cmd_ready,
    output logic [ADDR_W-1:0]            pc,
    output logic [NIB_W-1:0]             nib_out,
    output logic                         nib_valid,
    output logic [$clog2(N_NIB)-1:0]     nib_idx,
    output logic [$clog2(DEPTH+1)-1:0]   depth_cnt,
    output logic                         ovf,
    output logic                         unf
);

    localparam int unsigned IDX_W = $clog2(N_NIB);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_NIB - 1);

    state_e                       state_q;
    logic [N_NIB-1:0][NIB_W-1:0]  pc_q;
    logic [IDX_W-1:0]             idx_q;
    logic                         carry_q;
    logic [NIB_W-1:0]             nib_q;
    logic                         nib_valid_q;

    op_e                          op;
    logic                         cmd_fire;
    logic                         push_ok;
    logic                         pop_ok;
    logic [ADDR_W-1:0]            pop_data;
    logic [IDX_W-1:0]             idx_next;
    logic                         carry_in;
    logic [NIB_W:0]               inc_sum;

    assign op        = op_e'(cmd_op);
    assign cmd_ready = (state_q == StIdle) && !poc;
    assign cmd_fire  = cmd_valid && cmd_ready;

    always_comb begin
        idx_next = idx_q + IDX_W'(1);
        // The first nibble carries in the +1; later nibbles take the stored carry.
        carry_in = (idx_q == '0) ? 1'b1 : carry_q;
        inc_sum  = {1'b0, pc_q[idx_q]} + (NIB_W + 1)'(carry_in);
    end

    addr_stack_return_stack #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .OVF_MODE (OVF_MODE)
    ) u_return_stack (
        .sysclk    (sysclk),
        .poc       (poc),
        .push      (cmd_fire && (op == OpCall)),
        .pop       (cmd_fire && (op == OpRet)),
        .clr_flags (cmd_fire && (op == OpClrf)),
        .push_data (pc_q),
        .pop_data  (pop_data),
        .push_ok   (push_ok),
        .pop_ok    (pop_ok),
        .depth_cnt (depth_cnt),
        .ovf       (ovf),
        .unf       (unf)
    );

    always_ff @(posedge sysclk) begin
        if (poc) begin
            state_q     <= StIdle;
            pc_q        <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            nib_q       <= '0;
            nib_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (cmd_fire) begin
                        case (op)
                            OpFetch: begin
                                state_q     <= StEmit;
                                nib_valid_q <= 1'b1;
                                idx_q       <= '0;
                                nib_q       <= pc_q[0];
                            end
                            OpJump:  pc_q <= cmd_addr;
                            OpCall:  if (push_ok) pc_q <= cmd_addr;
                            OpRet:   if (pop_ok) pc_q <= pop_data;
                            OpJpage: pc_q[1:0] <= cmd_addr[2*NIB_W-1:0];
                            default: ;
                        endcase
                    end
                end
                StEmit: begin
                    pc_q[idx_q] <= inc_sum[NIB_W-1:0];
                    carry_q     <= inc_sum[NIB_W];
                    if (idx_q == LastIdx) begin
                        state_q     <= StIdle;
                        nib_valid_q <= 1'b0;
                        nib_q       <= '0;
                        idx_q       <= '0;
                    end else begin
                        idx_q <= idx_next;
                        nib_q <= pc_q[idx_next];
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign pc        = pc_q;
    assign nib_out   = nib_q;
    assign nib_valid = nib_valid_q;
    assign nib_idx   = idx_q;

endmodule

// File: tb/tb_addr_stack.sv
// Drives a wrap-mode and a trap-mode addr_stack in lockstep against a behavioural model.
module tb_addr_stack;

    logic        sysclk = 1'b0;
    logic        poc = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd_op = 3'd0;
    logic [11:0] cmd_addr = 12'd0;

    logic        rdy [2];
    logic [11:0] pc_w [2];
    logic [3:0]  nib_w [2];
    logic        nv [2];
    logic [1:0]  idx_w [2];
    logic [1:0]  dep_w [2];
    logic        ovf_w [2];
    logic        unf_w [2];

    always #5 sysclk = ~sysclk;

    addr_stack #(.OVF_MODE(0)) u_wrap (
        .sysclk (sysclk), .poc (poc), .cmd_valid (cmd_valid), .cmd_op (cmd_op),
        .cmd_addr (cmd_addr), .cmd_ready (rdy[0]), .pc (pc_w[0]), .nib_out (nib_w[0]),
        .nib_valid (nv[0]), .nib_idx (idx_w[0]), .depth_cnt (dep_w[0]), .ovf (ovf_w[0]),
        .unf (unf_w[0])
    );

    addr_stack #(.OVF_MODE(1)) u_trap (
        .sysclk (sysclk), .poc (poc), .cmd_valid (cmd_valid), .cmd_op (cmd_op),
        .cmd_addr (cmd_addr), .cmd_ready (rdy[1]), .pc (pc_w[1]), .nib_out (nib_w[1]),
        .nib_valid (nv[1]), .nib_idx (idx_w[1]), .depth_cnt (dep_w[1]), .ovf (ovf_w[1]),
        .unf (unf_w[1])
    );

    typedef struct {
        int idx;
        int n0;
        int n1;
    } nib_exp_t;

    nib_exp_t exp_q[$];
    int n_chk = 0;
    int n_pass = 0;

    // Reference model: index 0 is wrap mode, index 1 is trap mode.
    int m_pc [2];
    int m_sp [2];
    int m_cnt [2];
    int m_stk [2][3];
    bit m_ovf [2];
    bit m_unf [2];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            m_pc[m] = 0; m_sp[m] = 0; m_cnt[m] = 0; m_ovf[m] = 0; m_unf[m] = 0;
            for (int j = 0; j < 3; j++) m_stk[m][j] = 0;
        end
    endfunction

    function automatic void model_apply(input int op, input int addr);
        if (op == 0) begin
            for (int k = 0; k < 3; k++)
                exp_q.push_back('{k, (m_pc[0] >> (4 * k)) & 15, (m_pc[1] >> (4 * k)) & 15});
        end
        for (int m = 0; m < 2; m++) begin
            case (op)
                0: m_pc[m] = (m_pc[m] + 1) & 12'hFFF;
                1: m_pc[m] = addr;
                2: begin
                    if (m_cnt[m] == 3) m_ovf[m] = 1;
                    if (m_cnt[m] < 3 || m == 0) begin
                        m_stk[m][m_sp[m]] = m_pc[m];
                        m_sp[m] = (m_sp[m] + 1) % 3;
                        m_pc[m] = addr;
                        if (m_cnt[m] < 3) m_cnt[m]++;
                    end
                end
                3: begin
                    if (m_cnt[m] == 0) m_unf[m] = 1;
                    if (m_cnt[m] > 0 || m == 0) begin
                        m_sp[m] = (m_sp[m] + 2) % 3;
                        m_pc[m] = m_stk[m][m_sp[m]];
                        if (m_cnt[m] > 0) m_cnt[m]--;
                    end
                end
                4: m_pc[m] = (m_pc[m] & 12'hF00) | (addr & 12'h0FF);
                5: begin m_ovf[m] = 0; m_unf[m] = 0; end
                default: ;
            endcase
        end
    endfunction

    task automatic check_state(input string tag);
        for (int m = 0; m < 2; m++) begin
            check({tag, "_ready"}, int'(rdy[m]), 1);
            check({tag, "_pc"}, int'(pc_w[m]), m_pc[m]);
            check({tag, "_depth"}, int'(dep_w[m]), m_cnt[m]);
            check({tag, "_ovf"}, int'(ovf_w[m]), int'(m_ovf[m]));
            check({tag, "_unf"}, int'(unf_w[m]), int'(m_unf[m]));
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!(rdy[0] && rdy[1]) && n < 10) begin
            n++;
            @(posedge sysclk); #1;
        end
        check({tag, "_busy_cycles"}, n, 3);
    endtask

    task automatic issue(input int op, input int addr, input string tag);
        cmd_op = 3'(op);
        cmd_addr = 12'(addr);
        cmd_valid = 1'b1;
        model_apply(op, addr);
        @(posedge sysclk); #1;
        cmd_valid = 1'b0;
        if (op == 0) wait_ready(tag);
        check_state(tag);
    endtask

    task automatic do_reset();
        poc = 1'b1;
        @(posedge sysclk); #1;
        for (int m = 0; m < 2; m++) begin
            check("rst_ready_low", int'(rdy[m]), 0);
            check("rst_pc", int'(pc_w[m]), 0);
            check("rst_nib_valid", int'(nv[m]), 0);
            check("rst_depth", int'(dep_w[m]), 0);
            check("rst_flags", int'({ovf_w[m], unf_w[m]}), 0);
        end
        poc = 1'b0;
        model_reset();
        exp_q.delete();
        #1;
        check("rst_ready_high", int'(rdy[0] && rdy[1]), 1);
    endtask

    // Scoreboard monitor: every presented nibble must match the next expected one.
    always @(negedge sysclk) begin
        if (nv[0] || nv[1]) begin
            if (exp_q.size() == 0) begin
                check("nib_unexpected", int'(nv[0] | nv[1]), 0);
            end else begin
                nib_exp_t e;
                e = exp_q.pop_front();
                check("nib_valid_wrap", int'(nv[0]), 1);
                check("nib_valid_trap", int'(nv[1]), 1);
                check("nib_idx_wrap", int'(idx_w[0]), e.idx);
                check("nib_idx_trap", int'(idx_w[1]), e.idx);
                check("nib_out_wrap", int'(nib_w[0]), e.n0);
                check("nib_out_trap", int'(nib_w[1]), e.n1);
            end
        end else begin
            check("nib_idle_zero", int'({nib_w[0], nib_w[1]}), 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        model_reset();
        @(posedge sysclk); #1;
        do_reset();

        // Carry ripple across two nibbles, then full all-ones wrap.
        issue(1, 12'h0FF, "jump_0ff");
        issue(0, 0, "fetch_0ff");
        issue(1, 12'hFFF, "jump_fff");
        issue(0, 0, "fetch_fff");

        // Overflow and underflow policies for both modes.
        do_reset();
        issue(1, 12'h010, "jump_010");
        for (int i = 1; i <= 4; i++) issue(2, i * 12'h100, "call");
        issue(5, 0, "clrf_after_calls");
        for (int i = 0; i < 4; i++) issue(3, 0, "ret");
        issue(5, 0, "clrf_after_rets");

        // Page jump, then power-on clear in the middle of emission.
        issue(1, 12'h5A3, "jump_5a3");
        issue(4, 12'h0C7, "jpage_0c7");
        cmd_op = 3'd0; cmd_valid = 1'b1;
        model_apply(0, 0);
        @(posedge sysclk); #1;
        cmd_valid = 1'b0;
        @(posedge sysclk); #1;
        poc = 1'b1;
        @(posedge sysclk); #1;
        for (int m = 0; m < 2; m++) begin
            check("poc_emit_pc", int'(pc_w[m]), 0);
            check("poc_emit_nib_valid", int'(nv[m]), 0);
        end
        poc = 1'b0;
        model_reset();
        exp_q.delete();
        #1;

        // Command held during EMIT is ignored until the first ready cycle.
        issue(1, 12'h2E0, "jump_2e0");
        cmd_op = 3'd0; cmd_valid = 1'b1;
        model_apply(0, 0);
        @(posedge sysclk); #1;
        cmd_op = 3'd1; cmd_addr = 12'h123;
        wait_ready("held_fetch");
        check_state("held_before_jump");
        model_apply(1, 12'h123);
        @(posedge sysclk); #1;
        cmd_valid = 1'b0;
        check_state("held_jump_applied");

        // Randomised command stream with occasional power-on clear.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 49) == 0) do_reset();
            else issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 4095)), "rand");
        end

        @(posedge sysclk); #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
